// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 fetch/decode controller: state encoding,
// instruction field widths and the opcode extraction helper.
package lc3_pkg;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned OPCODE_W   = 4;
   localparam int unsigned WAIT_CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      F_MAR,
      F_MEM,
      F_IR,
      DECODE,
      EXEC,
      HALTED,
      FAULT
   } state_t;

   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] instr);
      return instr[WORD_W-1 -: OPCODE_W];
   endfunction

endpackage

// File: rtl/lc3_fetch_ctrl.sv
// LC-3 instruction fetch/decode sequencer: drives the datapath strobes for
// MAR<-PC, memory read, IR load and decode, with halt/resume and a memory timeout.
module lc3_fetch_ctrl
   import lc3_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic                resume,
   input  logic                halt_req,
   input  logic                mem_ready,
   input  logic                exec_done,
   input  logic [WORD_W-1:0]   ir,
   output logic                gate_pc,
   output logic                ld_mar,
   output logic                ld_pc,
   output logic                mem_en,
   output logic                ld_mdr,
   output logic                gate_mdr,
   output logic                ld_ir,
   output logic                dec_valid,
   output logic [OPCODE_W-1:0] opcode,
   output logic                halted,
   output logic                fault,
   output logic [WORD_W-1:0]   instr_count
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

   state_t                state, state_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  halt_pending;
   logic [WORD_W-1:0]     count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Wait counter is held at zero outside F_MEM, so it is already clear on entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt     <= '0;
         halt_pending <= 1'b0;
         count_q      <= '0;
      end else begin
         if (state != F_MEM) begin
            wait_cnt <= '0;
         end else if (!mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
         end

         if (state_nxt == HALTED && state != HALTED) begin
            halt_pending <= 1'b0;
         end else if (halt_req && state != FAULT && state != HALTED) begin
            halt_pending <= 1'b1;
         end

         if (state == F_IR) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (run) state_nxt = F_MAR;
         F_MAR:   state_nxt = F_MEM;
         F_MEM: begin
            if (mem_ready) begin
               state_nxt = F_IR;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt = FAULT;
            end
         end
         F_IR:    state_nxt = DECODE;
         DECODE:  state_nxt = EXEC;
         EXEC: begin
            if (exec_done) begin
               state_nxt = (halt_pending || halt_req) ? HALTED : F_MAR;
            end
         end
         HALTED:  if (resume) state_nxt = F_MAR;
         FAULT:   state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gate_pc   = 1'b0;
      ld_mar    = 1'b0;
      ld_pc     = 1'b0;
      mem_en    = 1'b0;
      gate_mdr  = 1'b0;
      ld_ir     = 1'b0;
      dec_valid = 1'b0;
      halted    = 1'b0;
      fault     = 1'b0;
      unique case (state)
         F_MAR: begin
            gate_pc = 1'b1;
            ld_mar  = 1'b1;
            ld_pc   = 1'b1;
         end
         F_MEM:  mem_en = 1'b1;
         F_IR: begin
            gate_mdr = 1'b1;
            ld_ir    = 1'b1;
         end
         DECODE, EXEC: dec_valid = 1'b1;
         HALTED: halted = 1'b1;
         FAULT:  fault = 1'b1;
         default: ;
      endcase
   end

   assign ld_mdr      = (state == F_MEM) && mem_ready;
   assign opcode      = dec_valid ? opcode_of(ir) : '0;
   assign instr_count = count_q;

endmodule

// File: tb/tb_lc3_fetch_ctrl.sv
// Directed-plus-random bench for lc3_fetch_ctrl; expectations come from an
// instruction-level model of the fetch sequence and a running fetch count.
module tb_lc3_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, run, resume, halt_req, mem_ready, exec_done;
   logic [15:0] ir;
   logic        gate_pc, ld_mar, ld_pc, mem_en, ld_mdr, gate_mdr, ld_ir;
   logic        dec_valid, halted, fault;
   logic [3:0]  opcode;
   logic [15:0] instr_count;

   int checks = 0;
   int errors = 0;
   int count_model = 0;

   // {gate_pc, ld_mar, ld_pc, mem_en, ld_mdr, gate_mdr, ld_ir, dec_valid, halted, fault}
   localparam logic [9:0] P_IDLE  = 10'b0000000000;
   localparam logic [9:0] P_MAR   = 10'b1110000000;
   localparam logic [9:0] P_MEM   = 10'b0001000000;
   localparam logic [9:0] P_MEMRD = 10'b0001100000;
   localparam logic [9:0] P_IR    = 10'b0000011000;
   localparam logic [9:0] P_DEC   = 10'b0000000100;
   localparam logic [9:0] P_HALT  = 10'b0000000010;
   localparam logic [9:0] P_FAULT = 10'b0000000001;

   always #5 clk = ~clk;

   lc3_fetch_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .run(run), .resume(resume), .halt_req(halt_req),
      .mem_ready(mem_ready), .exec_done(exec_done), .ir(ir),
      .gate_pc(gate_pc), .ld_mar(ld_mar), .ld_pc(ld_pc), .mem_en(mem_en),
      .ld_mdr(ld_mdr), .gate_mdr(gate_mdr), .ld_ir(ld_ir), .dec_valid(dec_valid),
      .opcode(opcode), .halted(halted), .fault(fault), .instr_count(instr_count)
   );

   function automatic logic [9:0] outs();
      return {gate_pc, ld_mar, ld_pc, mem_en, ld_mdr, gate_mdr, ld_ir, dec_valid, halted, fault};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_outs"}, 32'(outs()), 32'(P_IDLE));
      chk({tag, "_opcode"}, 32'(opcode), 32'h0);
      chk({tag, "_count"}, 32'(instr_count), 32'h0);
   endtask

   // Entered with the DUT in F_MAR. w = F_MEM cycles without mem_ready (< timeout),
   // ex = EXEC cycles, hmode: 0 none, 1 halt_req in first F_MEM cycle, 2 with exec_done.
   task automatic fetch(input int w, input logic [15:0] instr, input int ex, input int hmode);
      chk("f_mar", 32'(outs()), 32'(P_MAR));
      run = 1'($urandom_range(0, 1));
      tick();
      for (int k = 0; k <= w; k++) begin
         mem_ready = (k == w);
         halt_req  = (hmode == 1 && k == 0);
         run       = 1'($urandom_range(0, 1));
         #1;
         chk("f_mem", 32'(outs()), 32'((k == w) ? P_MEMRD : P_MEM));
         tick();
      end
      mem_ready = 1'b0;
      halt_req  = 1'b0;
      ir        = instr;
      chk("f_ir", 32'(outs()), 32'(P_IR));
      tick();
      count_model = (count_model + 1) % 65536;
      chk("decode", 32'(outs()), 32'(P_DEC));
      chk("dec_opcode", 32'(opcode), 32'(instr >> 12));
      chk("instr_count", 32'(instr_count), 32'(count_model));
      tick();
      for (int e = 0; e < ex; e++) begin
         exec_done = (e == ex - 1);
         halt_req  = (hmode == 2 && e == ex - 1);
         #1;
         chk("exec", 32'(outs()), 32'(P_DEC));
         chk("exec_opcode", 32'(opcode), 32'(instr >> 12));
         tick();
      end
      exec_done = 1'b0;
      halt_req  = 1'b0;
      if (hmode != 0) begin
         chk("halted", 32'(outs()), 32'(P_HALT));
         halt_req = 1'b1;
         run      = 1'b1;
         tick();
         halt_req = 1'b0;
         chk("halted_hold", 32'(outs()), 32'(P_HALT));
         resume = 1'b1;
         tick();
         resume = 1'b0;
      end
      run = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; resume = 1'b0; halt_req = 1'b0;
      mem_ready = 1'b0; exec_done = 1'b0; ir = 16'h0;
      tick();
      tick();
      rst = 1'b0;
      chk_cleared("reset");

      for (int i = 0; i < 3; i++) begin
         resume = 1'($urandom_range(0, 1));
         mem_ready = 1'($urandom_range(0, 1));
         tick();
         chk("idle_hold", 32'(outs()), 32'(P_IDLE));
      end
      resume = 1'b0; mem_ready = 1'b0;

      run = 1'b1;
      tick();
      run = 1'b0;
      fetch(0, 16'h1234, 2, 0);
      fetch(5, 16'($urandom), 1, 0);
      fetch(14, 16'($urandom), 3, 0);
      fetch(3, 16'($urandom), 2, 1);
      fetch(0, 16'($urandom), 1, 2);
      fetch(1, 16'($urandom), 1, 0);

      for (int i = 0; i < 40; i++) begin
         int hm;
         hm = $urandom_range(0, 5);
         fetch($urandom_range(0, 14), 16'($urandom), $urandom_range(1, 4), (hm > 2) ? 0 : hm);
      end

      // Reset in the middle of EXEC
      chk("pre_exec_mar", 32'(outs()), 32'(P_MAR));
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      tick();
      chk("pre_rst_exec", 32'(outs()), 32'(P_DEC));
      rst = 1'b1; exec_done = 1'b1; run = 1'b1; halt_req = 1'b1;
      tick();
      rst = 1'b0; exec_done = 1'b0; run = 1'b0; halt_req = 1'b0;
      count_model = 0;
      chk_cleared("rst_exec");

      // Memory never answers
      run = 1'b1;
      tick();
      run = 1'b0;
      chk("to_mar", 32'(outs()), 32'(P_MAR));
      tick();
      for (int k = 0; k < 15; k++) begin
         chk("to_mem", 32'(outs()), 32'(P_MEM));
         tick();
      end
      chk("fault", 32'(outs()), 32'(P_FAULT));
      for (int i = 0; i < 8; i++) begin
         run = 1'($urandom_range(0, 1));
         resume = 1'($urandom_range(0, 1));
         halt_req = 1'($urandom_range(0, 1));
         mem_ready = 1'($urandom_range(0, 1));
         exec_done = 1'($urandom_range(0, 1));
         tick();
         chk("fault_sticky", 32'(outs()), 32'(P_FAULT));
      end
      rst = 1'b1; run = 1'b1; resume = 1'b1; mem_ready = 1'b1;
      tick();
      rst = 1'b0; run = 1'b0; resume = 1'b0; halt_req = 1'b0;
      mem_ready = 1'b0; exec_done = 1'b0;
      chk_cleared("rst_fault");

      // A pending halt must not survive reset
      run = 1'b1;
      tick();
      run = 1'b0;
      fetch(2, 16'($urandom), 1, 0);

      // Counter wrap: preload to 0xFFFF while sitting in F_MAR
      force dut.count_q = 16'hFFFF;
      #1;
      release dut.count_q;
      #1;
      count_model = 65535;
      chk("count_preload", 32'(instr_count), 32'hFFFF);
      fetch(0, 16'($urandom), 1, 0);
      chk("count_wrap", 32'(instr_count), 32'h0);
      fetch(1, 16'($urandom), 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
